// File: rtl/instruction_fetch.sv
// Instruction fetch unit: a single-outstanding-request fetcher that walks the
// PC sequentially, holds one fetched word for the decoder, and restarts on
// branch/jump redirects, discarding any response that belongs to the old path.

package rriscv_pkg;
    parameter int XLEN = 32;
endpackage

module instruction_fetch #(
    parameter int               XLEN     = rriscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    // instruction memory
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    // control flow
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    // decoder side
    output logic [XLEN-1:0] instruction_o,
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o,
    input  logic            ready_i,
    output logic            misaligned_o
);

    // REQ: request pending, WAIT: granted and awaiting data,
    // FULL: word held for the decoder, DROP: awaiting a response to throw away
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q;
    logic [XLEN-1:0] pc_out_q;
    logic            misaligned_q;
    logic            capture;
    logic            req_raw;
    logic            valid_raw;
    logic [XLEN-1:0] redirect_target;
    logic [XLEN-1:0] pc_plus4;

    // Redirect targets are forced word-aligned; low bits only feed misaligned_o.
    assign redirect_target = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign pc_plus4        = pc_q + XLEN'(4);

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, next-pc and handshake decode; redirect wins over every other event
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        capture   = 1'b0;
        req_raw   = 1'b0;
        valid_raw = 1'b0;
        case (state_q)
            S_REQ: begin
                req_raw = !redirect_i;
                if (redirect_i) begin
                    pc_d = redirect_target;
                end else if (imem_gnt_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    pc_d    = redirect_target;
                    // a response arriving with the redirect is already the stale one
                    state_d = imem_rvalid_i ? S_REQ : S_DROP;
                end else if (imem_rvalid_i) begin
                    capture = 1'b1;
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                valid_raw = !redirect_i;
                if (redirect_i) begin
                    pc_d    = redirect_target;
                    state_d = S_REQ;
                end else if (ready_i) begin
                    pc_d    = pc_plus4;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect_i) begin
                    pc_d = redirect_target;
                end
                if (imem_rvalid_i) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Fetch PC and the held instruction/PC pair presented to the decoder
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
            if (capture) begin
                instr_q  <= imem_rdata_i;
                pc_out_q <= pc_q;
            end
        end
    end

    // One-cycle misaligned-target flag, registered off the redirect
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= redirect_i & (|redirect_pc_i[1:0]);
        end
    end

    // Handshakes are held low for the whole reset cycle, whatever the state register holds
    assign imem_req_o    = rst_ni & req_raw;
    assign valid_o       = rst_ni & valid_raw;
    assign imem_addr_o   = pc_q;
    assign instruction_o = instr_q;
    assign pc_o          = pc_out_q;
    assign misaligned_o  = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a memory responder (automatic or hand-driven)
// plus a scoreboard of expected {pc, instruction} transfers.

module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;
    logic        misaligned_o;

    logic        auto_mode;
    logic        man_gnt;
    logic        man_rvalid;
    logic [31:0] man_rdata;
    logic        pend = 1'b0;
    logic [31:0] paddr = '0;

    int          total = 0;
    int          bad = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_e;

    instruction_fetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instruction_o (instruction_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .misaligned_o  (misaligned_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return a ^ 32'h5A5A_3C3C;
    endfunction

    // Automatic memory: grants every request at once, answers one cycle later
    assign imem_gnt_i    = auto_mode ? imem_req_o : man_gnt;
    assign imem_rvalid_i = auto_mode ? pend : man_rvalid;
    assign imem_rdata_i  = auto_mode ? mem_word(paddr) : man_rdata;

    always @(posedge clk) begin
        if (!auto_mode) begin
            pend <= 1'b0;
        end else begin
            pend  <= imem_req_o && imem_gnt_i;
            paddr <= imem_addr_o;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic automode);
        next_cycle();
        rst_ni = 1'b0; redirect_i = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b0;
        auto_mode = automode; ready_i = 1'b1;
        next_cycle();
        next_cycle();
        rst_ni = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; ready_i = 1'b1;
        auto_mode = 1'b1; man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = '0;
        repeat (3) next_cycle();
        #1;
        total++;
        if (imem_req_o !== 1'b0 || valid_o !== 1'b0) begin
            bad++; $display("FAIL reset_hs: req=%b valid=%b want 0 0", imem_req_o, valid_o);
        end
        total++;
        if (pc_o !== 32'h0 || instruction_o !== 32'h0 || misaligned_o !== 1'b0) begin
            bad++; $display("FAIL reset_regs: pc_o=%h instr=%h mis=%b want 0 0 0", pc_o, instruction_o, misaligned_o);
        end
    endtask

    task automatic test_first_fetch();
        rst_ni = 1'b1;
        sb.push_back({32'h0, mem_word(32'h0)});
        #1;
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            bad++; $display("FAIL first_req: req=%b addr=%h want 1 0", imem_req_o, imem_addr_o);
        end
        next_cycle(); #1;
        total++;
        if (valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
            bad++; $display("FAIL first_wait: valid=%b req=%b want 0 0", valid_o, imem_req_o);
        end
        next_cycle(); #1;
        total++;
        if (valid_o !== 1'b1 || imem_req_o !== 1'b0) begin
            bad++; $display("FAIL first_valid: valid=%b req=%b want 1 0", valid_o, imem_req_o);
        end
        if (valid_o && ready_i) begin
            total++; exp_e = sb.pop_front();
            if ({pc_o, instruction_o} !== exp_e) begin
                bad++; $display("FAIL first_xfer: got %h/%h want %h/%h", pc_o, instruction_o, exp_e[63:32], exp_e[31:0]);
            end
        end
        next_cycle(); #1;
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
            bad++; $display("FAIL first_next: req=%b addr=%h want 1 4", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_stall();
        int n;
        logic [31:0] h_i, h_p;
        ready_i = 1'b0;
        sb.push_back({32'h4, mem_word(32'h4)});
        n = 0;
        while (!valid_o && n < 10) begin next_cycle(); #1; n++; end
        total++;
        if (valid_o !== 1'b1) begin bad++; $display("FAIL stall_timeout: valid=%b want 1", valid_o); end
        h_i = instruction_o; h_p = pc_o;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (valid_o !== 1'b1 || imem_req_o !== 1'b0 || instruction_o !== h_i || pc_o !== h_p) begin
                bad++; $display("FAIL stall_hold: valid=%b req=%b %h/%h want 1 0 %h/%h", valid_o, imem_req_o, pc_o, instruction_o, h_p, h_i);
            end
            next_cycle(); #1;
        end
        ready_i = 1'b1;
        #1;
        total++;
        if (!(valid_o && ready_i) || sb.size() == 0) begin
            bad++; $display("FAIL stall_release: valid=%b want 1", valid_o);
        end else begin
            exp_e = sb.pop_front();
            if ({pc_o, instruction_o} !== exp_e) begin
                bad++; $display("FAIL stall_xfer: got %h/%h want %h/%h", pc_o, instruction_o, exp_e[63:32], exp_e[31:0]);
            end
        end
        next_cycle(); #1;
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin
            bad++; $display("FAIL stall_next: req=%b addr=%h want 1 8", imem_req_o, imem_addr_o);
        end
    endtask

    task automatic test_back_to_back();
        int xfers = 0;
        ready_i = 1'b1;
        for (int k = 0; k < 6; k++) sb.push_back({32'h8 + 32'(4*k), mem_word(32'h8 + 32'(4*k))});
        for (int c = 0; c < 18; c++) begin
            if (valid_o && ready_i) begin
                total++; xfers++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL b2b_extra: got %h/%h want none", pc_o, instruction_o);
                end else begin
                    exp_e = sb.pop_front();
                    if ({pc_o, instruction_o} !== exp_e) begin
                        bad++; $display("FAIL b2b_xfer: got %h/%h want %h/%h", pc_o, instruction_o, exp_e[63:32], exp_e[31:0]);
                    end
                end
            end
            next_cycle(); #1;
        end
        total++;
        if (xfers != 6 || imem_addr_o !== 32'h20) begin
            bad++; $display("FAIL b2b_rate: xfers=%0d addr=%h want 6 00000020", xfers, imem_addr_o);
        end
    endtask

    task automatic test_random_ready();
        int n = 0;
        logic hold = 1'b0;
        logic [31:0] h_i = '0, h_p = '0;
        for (int k = 0; k < 8; k++) sb.push_back({32'h20 + 32'(4*k), mem_word(32'h20 + 32'(4*k))});
        while (sb.size() != 0 && n < 200) begin
            ready_i = 1'($urandom_range(0, 1));
            #1;
            if (hold) begin
                total++;
                if (valid_o !== 1'b1 || instruction_o !== h_i || pc_o !== h_p) begin
                    bad++; $display("FAIL rnd_hold: valid=%b %h/%h want 1 %h/%h", valid_o, pc_o, instruction_o, h_p, h_i);
                end
            end
            hold = valid_o && !ready_i; h_i = instruction_o; h_p = pc_o;
            if (valid_o && ready_i) begin
                total++; exp_e = sb.pop_front();
                if ({pc_o, instruction_o} !== exp_e) begin
                    bad++; $display("FAIL rnd_xfer: got %h/%h want %h/%h", pc_o, instruction_o, exp_e[63:32], exp_e[31:0]);
                end
            end
            next_cycle(); n++;
        end
        ready_i = 1'b1;
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL rnd_timeout: left=%0d want 0", sb.size()); end
    endtask

    task automatic test_redirect_wait();
        int n = 0;
        do_reset(1'b0);
        man_gnt = 1'b1; #1;
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            bad++; $display("FAIL rw_req: req=%b addr=%h want 1 0", imem_req_o, imem_addr_o);
        end
        next_cycle();
        man_gnt = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h100; #1;
        total++;
        if (imem_req_o !== 1'b0 || valid_o !== 1'b0) begin
            bad++; $display("FAIL rw_redir: req=%b valid=%b want 0 0", imem_req_o, valid_o);
        end
        next_cycle();
        redirect_i = 1'b0; #1;
        total++;
        if (imem_req_o !== 1'b0 || valid_o !== 1'b0 || misaligned_o !== 1'b0) begin
            bad++; $display("FAIL rw_drop: req=%b valid=%b mis=%b want 0 0 0", imem_req_o, valid_o, misaligned_o);
        end
        next_cycle();
        man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF; #1;
        total++;
        if (valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
            bad++; $display("FAIL rw_stale: valid=%b req=%b want 0 0", valid_o, imem_req_o);
        end
        next_cycle();
        man_rvalid = 1'b0; #1;
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || valid_o !== 1'b0) begin
            bad++; $display("FAIL rw_restart: req=%b addr=%h valid=%b want 1 00000100 0", imem_req_o, imem_addr_o, valid_o);
        end
        auto_mode = 1'b1;
        sb.push_back({32'h100, mem_word(32'h100)});
        while (sb.size() != 0 && n < 10) begin
            #1;
            if (valid_o && ready_i) begin
                total++; exp_e = sb.pop_front();
                if ({pc_o, instruction_o} !== exp_e) begin
                    bad++; $display("FAIL rw_xfer: got %h/%h want %h/%h", pc_o, instruction_o, exp_e[63:32], exp_e[31:0]);
                end
            end
            next_cycle(); n++;
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL rw_timeout: left=%0d want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_redirect_full();
        int n = 0;
        do_reset(1'b1);
        ready_i = 1'b0;
        while (!valid_o && n < 10) begin next_cycle(); #1; n++; end
        total++;
        if (valid_o !== 1'b1) begin bad++; $display("FAIL rf_timeout: valid=%b want 1", valid_o); end
        ready_i = 1'b1; redirect_i = 1'b1; redirect_pc_i = 32'h103; #1;
        total++;
        if (valid_o !== 1'b0 || imem_req_o !== 1'b0) begin
            bad++; $display("FAIL rf_kill: valid=%b req=%b want 0 0", valid_o, imem_req_o);
        end
        next_cycle();
        redirect_i = 1'b0; #1;
        total++;
        if (misaligned_o !== 1'b1 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100 || valid_o !== 1'b0) begin
            bad++; $display("FAIL rf_restart: mis=%b req=%b addr=%h valid=%b want 1 1 00000100 0", misaligned_o, imem_req_o, imem_addr_o, valid_o);
        end
        sb.push_back({32'h100, mem_word(32'h100)});
        next_cycle(); #1;
        total++;
        if (misaligned_o !== 1'b0) begin bad++; $display("FAIL rf_pulse: mis=%b want 0", misaligned_o); end
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            if (valid_o && ready_i) begin
                total++; exp_e = sb.pop_front();
                if ({pc_o, instruction_o} !== exp_e) begin
                    bad++; $display("FAIL rf_xfer: got %h/%h want %h/%h", pc_o, instruction_o, exp_e[63:32], exp_e[31:0]);
                end
            end
            next_cycle(); #1; n++;
        end
        total++;
        if (sb.size() != 0) begin bad++; $display("FAIL rf_timeout2: left=%0d want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_wrap();
        int n = 0;
        do_reset(1'b1);
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; #1;
        total++;
        if (imem_req_o !== 1'b0) begin bad++; $display("FAIL wrap_suppress: req=%b want 0", imem_req_o); end
        next_cycle();
        redirect_i = 1'b0; #1;
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hFFFF_FFFC) begin
            bad++; $display("FAIL wrap_req: req=%b addr=%h want 1 fffffffc", imem_req_o, imem_addr_o);
        end
        sb.push_back({32'hFFFF_FFFC, mem_word(32'hFFFF_FFFC)});
        while (sb.size() != 0 && n < 10) begin
            if (valid_o && ready_i) begin
                total++; exp_e = sb.pop_front();
                if ({pc_o, instruction_o} !== exp_e) begin
                    bad++; $display("FAIL wrap_xfer: got %h/%h want %h/%h", pc_o, instruction_o, exp_e[63:32], exp_e[31:0]);
                end
            end
            next_cycle(); #1; n++;
        end
        total++;
        if (sb.size() != 0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
            bad++; $display("FAIL wrap_next: left=%0d req=%b addr=%h want 0 1 00000000", sb.size(), imem_req_o, imem_addr_o);
            sb.delete();
        end
    endtask

    task automatic test_drop_redirects();
        do_reset(1'b0);
        man_gnt = 1'b1;
        next_cycle();
        man_gnt = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h200; man_rvalid = 1'b1; man_rdata = 32'hBAD0_BAD0; #1;
        total++;
        if (valid_o !== 1'b0) begin bad++; $display("FAIL dr_same: valid=%b want 0", valid_o); end
        next_cycle();
        redirect_i = 1'b0; man_rvalid = 1'b0; man_gnt = 1'b1; #1;
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
            bad++; $display("FAIL dr_req200: req=%b addr=%h want 1 00000200", imem_req_o, imem_addr_o);
        end
        next_cycle();
        man_gnt = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h300; #1;
        next_cycle();
        redirect_pc_i = 32'h302; #1;
        total++;
        if (imem_req_o !== 1'b0 || misaligned_o !== 1'b0) begin
            bad++; $display("FAIL dr_drop: req=%b mis=%b want 0 0", imem_req_o, misaligned_o);
        end
        next_cycle();
        redirect_i = 1'b0; man_rvalid = 1'b1; #1;
        total++;
        if (imem_req_o !== 1'b0 || misaligned_o !== 1'b1 || valid_o !== 1'b0) begin
            bad++; $display("FAIL dr_still: req=%b mis=%b valid=%b want 0 1 0", imem_req_o, misaligned_o, valid_o);
        end
        next_cycle();
        man_rvalid = 1'b0; #1;
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h300 || valid_o !== 1'b0) begin
            bad++; $display("FAIL dr_restart: req=%b addr=%h valid=%b want 1 00000300 0", imem_req_o, imem_addr_o, valid_o);
        end
    endtask

    task automatic test_reset_in_wait();
        do_reset(1'b0);
        redirect_i = 1'b1; redirect_pc_i = 32'h40;
        next_cycle();
        redirect_i = 1'b0; man_gnt = 1'b1; #1;
        next_cycle();
        man_gnt = 1'b0; rst_ni = 1'b0; #1;
        total++;
        if (imem_req_o !== 1'b0 || valid_o !== 1'b0) begin
            bad++; $display("FAIL rst_wait_hs: req=%b valid=%b want 0 0", imem_req_o, valid_o);
        end
        next_cycle();
        rst_ni = 1'b1; man_rvalid = 1'b1; man_rdata = 32'h1234_5678; #1;
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || valid_o !== 1'b0) begin
            bad++; $display("FAIL rst_wait_req: req=%b addr=%h valid=%b want 1 0 0", imem_req_o, imem_addr_o, valid_o);
        end
        next_cycle();
        man_rvalid = 1'b0; #1;
        total++;
        if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || valid_o !== 1'b0) begin
            bad++; $display("FAIL rst_wait_ignore: req=%b addr=%h valid=%b want 1 0 0", imem_req_o, imem_addr_o, valid_o);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_back_to_back();
        test_random_ready();
        test_redirect_wait();
        test_redirect_full();
        test_wrap();
        test_drop_redirects();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
